mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- MEM stage of the 5-stage RV32I pipeline; sits directly downstream of the EX/MEM register and upstream of MEM/WB.
- Non-memory instructions pass straight through, combinationally, in the same cycle.
- Loads and stores go through a byte-wide memory-controller port, one byte per handshake. The block raises stall_req to freeze the pipeline until the access completes.
- Outputs also drive the ID-stage forwarding path.

Parameters:
- XLEN, 32, data and address width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  RV32I opcode. 7'b0000011 = LOAD, 7'b0100011 = STORE.
- funct3  in  3  size/sign field: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
- we  in  1  register write enable from EX.
- waddr  in  5  destination register.
- alu  in  XLEN  ALU result; this is the effective address for LOAD/STORE.
- rdata2  in  XLEN  store data (rs2).
- mc_rdata  in  8  read byte, valid in the cycle mc_ack is high.
- mc_ack  in  1  memory controller accepted the current byte request.
- mc_req  out  1  byte request valid.
- mc_we  out  1  1 = write byte, 0 = read byte.
- mc_addr  out  XLEN  byte address.
- mc_wdata  out  8  write byte.
- stall_req  out  1  to pipeline control. While high, EX/MEM and earlier stages hold.
- wb_we  out  1  write enable to MEM/WB and forwarding.
- wb_waddr  out  5  destination register.
- wb_wdata  out  XLEN  result data.

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
  - On rst: state goes to IDLE, byte index = 0, load buffer = 0.
  - While rst is high, every output is 0 regardless of inputs.
- Access size N: 1 if funct3[1:0]=0, 2 if 1, 4 otherwise. Byte index is 2 bits.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Non-memory opcode: wb_we = we, wb_waddr = waddr, wb_wdata = alu, stall_req = 0, mc_req = 0. Stay in IDLE.
  - LOAD or STORE: stall_req = 1, wb_we = 0, mc_req = 0. Next state BUSY, index <= 0.
- BUSY:
  - Outputs: stall_req = 1, wb_we = 0, mc_req = 1, mc_we = (opcode == STORE).
  - mc_addr = alu + index, with XLEN-bit wrap-around at the top of the address space.
  - mc_wdata = rdata2[8*index+7 : 8*index] (little-endian).
  - mc_req, mc_we, mc_addr and mc_wdata stay stable until mc_ack.
  - On mc_ack: for a load, buffer byte[index] <= mc_rdata. If index == N-1, go to DONE; otherwise index <= index+1.
  - No mc_ack: hold everything.
- DONE (exactly 1 cycle):
  - stall_req = 0, mc_req = 0.
  - LOAD: wb_we = we, wb_waddr = waddr, wb_wdata = buffer extended to XLEN. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW is used as-is.
  - STORE: wb_we = 0.
  - Next state IDLE. EX/MEM advances at this edge, so the same access is never reissued.
- Latency: a memory op costs N mc_ack cycles + 2 stall-free-boundary cycles. With mc_ack tied high this is N+2 cycles, and stall_req is high for N+1 of them.
- Misaligned addresses are legal and need no special handling.
- Unused load bytes (above N) are masked by the extension, never taken from stale buffer contents.
- Reset during BUSY: mc_req drops in the reset cycle. The partial access is abandoned and the next state is IDLE.
- mc_ack in IDLE or DONE is ignored.
- Inputs are assumed stable whenever stall_req is high; pipeline control guarantees this.

Test Plan:
- ALU op: opcode 7'b0110011, we=1, waddr=5, alu=32'h1234 → same cycle wb_we=1, wb_waddr=5, wb_wdata=32'h1234, stall_req=0, mc_req=0.
- LW, mc_ack tied high: addr 0x100, memory bytes 0x100..0x103 = 78,56,34,12 → reads 0x100..0x103 in order. DONE gives wb_wdata=32'h12345678, wb_we=1. stall_req is high for exactly 5 cycles.
- LB at 0x7 = 0x80 → wb_wdata=32'hFFFFFF80. LBU at the same address → 32'h00000080.
- SH: addr 0x203, rdata2=32'hAABBCCDD → writes 0xDD to 0x203, then 0xCC to 0x204. mc_we=1. wb_we=0 throughout.
- LW with mc_ack delayed 3 cycles on byte 1 → mc_addr holds 0x101 during the wait. Final result is correct and stall_req stays high during the wait.
- rst asserted in BUSY after 2 bytes of an LW → next cycle all outputs are 0 and state is IDLE. A following ALU op passes through correctly.

Source files
------------

// File: rtl/mem_access_if.sv
// Byte-wide memory-controller port used by the MEM stage for loads and stores.
interface mem_access_if #(parameter int unsigned XLEN = 32);
  logic            mc_req;
  logic            mc_we;
  logic [XLEN-1:0] mc_addr;
  logic [7:0]      mc_wdata;
  logic [7:0]      mc_rdata;
  logic            mc_ack;

  modport master (output mc_req, mc_we, mc_addr, mc_wdata, input mc_rdata, mc_ack);
  modport slave  (input mc_req, mc_we, mc_addr, mc_wdata, output mc_rdata, mc_ack);
endinterface

// File: rtl/mem_access.sv
// RV32I MEM stage: ALU results pass through combinationally; loads/stores are
// serialised one byte per handshake over the memory-controller port while stalling.
module mem_access #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] rdata2,
  mem_access_if.master    mc,
  output logic            stall_req,
  output logic            wb_we,
  output logic [4:0]      wb_waddr,
  output logic [XLEN-1:0] wb_wdata
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] buf_q, buf_d;

  logic        is_load;
  logic        is_store;
  logic [1:0]  last_idx;
  logic [XLEN-1:0] load_val;

  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign last_idx = (funct3[1:0] == 2'd0) ? 2'd0 :
                    (funct3[1:0] == 2'd1) ? 2'd1 : 2'd3;

  // Extension masks bytes above the access size, so stale buffer bytes never leak.
  always_comb begin
    case (funct3)
      3'd0:    load_val = {{(XLEN-8){buf_q[7]}}, buf_q[7:0]};
      3'd1:    load_val = {{(XLEN-16){buf_q[15]}}, buf_q[15:0]};
      3'd4:    load_val = {{(XLEN-8){1'b0}}, buf_q[7:0]};
      3'd5:    load_val = {{(XLEN-16){1'b0}}, buf_q[15:0]};
      default: load_val = XLEN'(buf_q);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      buf_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    buf_d       = buf_q;
    stall_req   = 1'b0;
    wb_we       = 1'b0;
    wb_waddr    = 5'd0;
    wb_wdata    = '0;
    mc.mc_req   = 1'b0;
    mc.mc_we    = 1'b0;
    mc.mc_addr  = '0;
    mc.mc_wdata = 8'd0;

    case (state_q)
      IDLE: begin
        if (is_load || is_store) begin
          stall_req = 1'b1;
          state_d   = BUSY;
          idx_d     = 2'd0;
        end else begin
          wb_we    = we;
          wb_waddr = waddr;
          wb_wdata = alu;
        end
      end
      BUSY: begin
        stall_req   = 1'b1;
        mc.mc_req   = 1'b1;
        mc.mc_we    = is_store;
        mc.mc_addr  = alu + XLEN'(idx_q);
        mc.mc_wdata = rdata2[{idx_q, 3'b000} +: 8];
        if (mc.mc_ack) begin
          if (is_load) begin
            case (idx_q)
              2'd0:    buf_d[7:0]   = mc.mc_rdata;
              2'd1:    buf_d[15:8]  = mc.mc_rdata;
              2'd2:    buf_d[23:16] = mc.mc_rdata;
              default: buf_d[31:24] = mc.mc_rdata;
            endcase
          end
          if (idx_q == last_idx) state_d = DONE;
          else                   idx_d   = idx_q + 2'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (is_load) begin
          wb_we    = we;
          wb_waddr = waddr;
          wb_wdata = load_val;
        end
      end
      default: state_d = IDLE;
    endcase

    // Reset forces every output low in the same cycle, including an in-flight request.
    if (rst) begin
      stall_req   = 1'b0;
      wb_we       = 1'b0;
      wb_waddr    = 5'd0;
      wb_wdata    = '0;
      mc.mc_req   = 1'b0;
      mc.mc_we    = 1'b0;
      mc.mc_addr  = '0;
      mc.mc_wdata = 8'd0;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: stimulus pushes expected byte transfers and
// writebacks; a monitor pops and compares whenever the DUT presents them.
module tb_mem_access;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
  } mreq_t;

  typedef struct {
    logic [4:0]  waddr;
    logic [31:0] data;
  } wb_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] alu;
  logic [31:0] rdata2;
  logic        stall_req;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  mem_access_if #(.XLEN(32)) mc_if();

  mem_access #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .we(we),
    .waddr(waddr), .alu(alu), .rdata2(rdata2), .mc(mc_if),
    .stall_req(stall_req), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;

  int checks = 0;
  int failures = 0;
  mreq_t mq[$];
  wb_t   wq[$];

  logic [7:0]  mem [0:1023];
  logic [31:0] delay_addr = 32'hFFFF_FFFF;
  int          delay_cnt = 0;

  assign mc_if.mc_rdata = mem[mc_if.mc_addr[9:0]];

  // Memory responder: acks every request except the one being deliberately delayed.
  always @(negedge clk) begin
    if (mc_if.mc_req && mc_if.mc_addr == delay_addr && delay_cnt > 0) begin
      mc_if.mc_ack = 1'b0;
      delay_cnt    = delay_cnt - 1;
    end else begin
      mc_if.mc_ack = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: compares each accepted byte transfer and each writeback against the queues.
  always @(negedge clk) begin
    #1;
    if (rst !== 1'b1) begin
      if (mc_if.mc_req === 1'b1 && mc_if.mc_ack === 1'b1) begin
        if (mq.size() == 0) begin
          checks++; failures++;
          $display("FAIL mc_unexpected: got addr %h we %b expected no request", mc_if.mc_addr, mc_if.mc_we);
        end else begin
          mreq_t e;
          e = mq.pop_front();
          chk("mc_we", 32'(mc_if.mc_we), 32'(e.we));
          chk("mc_addr", mc_if.mc_addr, e.addr);
          if (e.we) chk("mc_wdata", 32'(mc_if.mc_wdata), 32'(e.wdata));
        end
      end
      if (wb_we === 1'b1) begin
        if (wq.size() == 0) begin
          checks++; failures++;
          $display("FAIL wb_unexpected: got waddr %0d data %h expected no writeback", wb_waddr, wb_wdata);
        end else begin
          wb_t w;
          w = wq.pop_front();
          chk("wb_waddr", 32'(wb_waddr), 32'(w.waddr));
          chk("wb_wdata", wb_wdata, w.data);
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk); #2;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic w,
                       input logic [4:0] wa, input logic [31:0] a, input logic [31:0] d);
    opcode = op; funct3 = f3; we = w; waddr = wa; alu = a; rdata2 = d;
  endtask

  task automatic push_m(input logic w, input logic [31:0] a, input logic [7:0] d);
    mreq_t e;
    e.we = w; e.addr = a; e.wdata = d;
    mq.push_back(e);
  endtask

  task automatic push_w(input logic [4:0] wa, input logic [31:0] d);
    wb_t e;
    e.waddr = wa; e.data = d;
    wq.push_back(e);
  endtask

  // Waits for the access to finish, counting stalled cycles; ends at the IDLE cycle after DONE.
  task automatic wait_done(input string name, input int exp_stall, input logic [31:0] wait_addr);
    int n = 0;
    bit done = 0;
    for (int c = 0; c < 50 && !done; c++) begin
      sample();
      if (mc_if.mc_req === 1'b1 && mc_if.mc_ack === 1'b0) begin
        chk({name, "_wait_addr"}, mc_if.mc_addr, wait_addr);
        chk({name, "_wait_stall"}, 32'(stall_req), 32'd1);
      end
      if (stall_req === 1'b1) n++;
      else done = 1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got stall still high expected completion", name);
    end
    chk({name, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[10'h100] = 8'h78; mem[10'h101] = 8'h56; mem[10'h102] = 8'h34; mem[10'h103] = 8'h12;
    mem[10'h007] = 8'h80;
    mem[10'h3FE] = 8'h11; mem[10'h3FF] = 8'h22; mem[10'h000] = 8'h33; mem[10'h001] = 8'h44;
    mem[10'h200] = 8'h00; mem[10'h201] = 8'h90;

    rst = 1'b1;
    drive(OP_ALU, 3'd0, 1'b1, 5'd9, 32'hDEAD_BEEF, 32'h0);
    next_cycle(); next_cycle();
    sample();
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_wb_we", 32'(wb_we), 32'd0);
    chk("rst_wb_wdata", wb_wdata, 32'd0);
    chk("rst_mc_req", 32'(mc_if.mc_req), 32'd0);
    next_cycle();
    rst = 1'b0;

    drive(OP_ALU, 3'd0, 1'b1, 5'd5, 32'h0000_1234, 32'h0);
    push_w(5'd5, 32'h0000_1234);
    sample();
    chk("alu_stall", 32'(stall_req), 32'd0);
    chk("alu_mc_req", 32'(mc_if.mc_req), 32'd0);
    next_cycle();

    push_m(0, 32'h100, 8'h00); push_m(0, 32'h101, 8'h00);
    push_m(0, 32'h102, 8'h00); push_m(0, 32'h103, 8'h00);
    push_w(5'd10, 32'h1234_5678);
    drive(OP_LOAD, 3'd2, 1'b1, 5'd10, 32'h100, 32'h0);
    wait_done("lw", 5, 32'h0);

    push_m(0, 32'h7, 8'h00); push_w(5'd3, 32'hFFFF_FF80);
    drive(OP_LOAD, 3'd0, 1'b1, 5'd3, 32'h7, 32'h0);
    wait_done("lb", 2, 32'h0);

    push_m(0, 32'h7, 8'h00); push_w(5'd4, 32'h0000_0080);
    drive(OP_LOAD, 3'd4, 1'b1, 5'd4, 32'h7, 32'h0);
    wait_done("lbu", 2, 32'h0);

    push_m(1, 32'h203, 8'hDD); push_m(1, 32'h204, 8'hCC);
    drive(OP_STORE, 3'd1, 1'b1, 5'd6, 32'h203, 32'hAABB_CCDD);
    wait_done("sh", 3, 32'h0);

    push_m(0, 32'hFFFF_FFFE, 8'h00); push_m(0, 32'hFFFF_FFFF, 8'h00);
    push_m(0, 32'h0, 8'h00);         push_m(0, 32'h1, 8'h00);
    push_w(5'd11, 32'h4433_2211);
    drive(OP_LOAD, 3'd2, 1'b1, 5'd11, 32'hFFFF_FFFE, 32'h0);
    wait_done("lw_wrap", 5, 32'h0);

    push_m(0, 32'h200, 8'h00); push_m(0, 32'h201, 8'h00);
    push_w(5'd12, 32'hFFFF_9000);
    drive(OP_LOAD, 3'd1, 1'b1, 5'd12, 32'h200, 32'h0);
    wait_done("lh", 3, 32'h0);

    push_m(0, 32'h200, 8'h00); push_m(0, 32'h201, 8'h00);
    push_w(5'd13, 32'h0000_9000);
    drive(OP_LOAD, 3'd5, 1'b1, 5'd13, 32'h200, 32'h0);
    wait_done("lhu", 3, 32'h0);

    delay_addr = 32'h101; delay_cnt = 3;
    push_m(0, 32'h100, 8'h00); push_m(0, 32'h101, 8'h00);
    push_m(0, 32'h102, 8'h00); push_m(0, 32'h103, 8'h00);
    push_w(5'd14, 32'h1234_5678);
    drive(OP_LOAD, 3'd2, 1'b1, 5'd14, 32'h100, 32'h0);
    wait_done("lw_delay", 8, 32'h101);
    delay_addr = 32'hFFFF_FFFF;

    push_m(0, 32'h100, 8'h00); push_m(0, 32'h101, 8'h00);
    drive(OP_LOAD, 3'd2, 1'b1, 5'd15, 32'h100, 32'h0);
    next_cycle(); next_cycle(); next_cycle();
    rst = 1'b1;
    sample();
    chk("brst_stall", 32'(stall_req), 32'd0);
    chk("brst_mc_req", 32'(mc_if.mc_req), 32'd0);
    chk("brst_mc_addr", mc_if.mc_addr, 32'd0);
    chk("brst_wb_we", 32'(wb_we), 32'd0);
    next_cycle();
    rst = 1'b0;
    drive(OP_ALU, 3'd0, 1'b1, 5'd7, 32'h0000_0055, 32'h0);
    push_w(5'd7, 32'h0000_0055);
    sample();
    chk("post_rst_stall", 32'(stall_req), 32'd0);
    chk("post_rst_mc_req", 32'(mc_if.mc_req), 32'd0);
    next_cycle();

    drive(OP_IMM, 3'd0, 1'b0, 5'd0, 32'h0, 32'h0);
    repeat (4) next_cycle();
    chk("mq_drained", 32'(mq.size()), 32'd0);
    chk("wq_drained", 32'(wq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
